// File: rtl/cia_pipelined_subtractor.sv
// Pipelined, flow-controlled subtractor: diff = (a - b - bin) mod 2^N.
// The operand is split into S = N/GS groups; pipeline stage k resolves group k
// in carry-increment style and hands its borrow to stage k+1. Valid/ready
// handshakes on both sides, bubble-collapsing stalls, one operation per cycle.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready    operand handshake (in_ready is combinational from
//                         out_ready and the stage valid bits only)
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid, out_ready  result handshake
//   diff, bout, ovf       difference, unsigned borrow-out, signed overflow
module cia_pipelined_subtractor #(
  parameter int unsigned N  = 16,
  parameter int unsigned GS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:1]   a,
  input  logic [N:1]   b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:1]   diff,
  output logic         bout,
  output logic         ovf
);

  localparam int unsigned S = N / GS;

  if (((N % GS) != 0) || (GS < 2)) begin : g_bad_param
    $error("cia_pipelined_subtractor: N must be a multiple of GS and GS >= 2");
  end

  // One group: a + ~b + ~borrow_in, computed for both carry-ins and selected.
  // Returns {borrow_out, group_diff}.
  function automatic logic [GS:0] grp_sub(input logic [GS-1:0] ga,
                                           input logic [GS-1:0] gb,
                                           input logic          gbin);
    logic [GS-1:0] p;
    logic [GS-1:0] g;
    logic [GS-1:0] s0;
    logic [GS-1:0] s1;
    logic          c;
    logic          c0;
    logic          c1;
    p = ga ^ ~gb;
    g = ga & ~gb;
    c = 1'b0;
    for (int i = 0; i < int'(GS); i++) begin
      s0[i] = p[i] ^ c;
      c     = g[i] | (p[i] & c);
    end
    c0 = c;
    // Carry-in of 1 increments the carry-0 sum; carry-out only changes when
    // every bit propagates.
    s1 = s0 + GS'(1);
    c1 = c0 | (&p);
    // Borrow-in 0 means carry-in 1 in the a + ~b formulation.
    grp_sub = gbin ? {~c0, s0} : {~c1, s1};
  endfunction

  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  assign a_in = a;
  assign b_in = b;

  // Stage registers: full operands travel so upper groups and the sign bits
  // for overflow are available downstream; resolved bits accumulate in d_r.
  logic         v     [S];
  logic         brw_r [S];
  logic [N-1:0] a_r   [S];
  logic [N-1:0] b_r   [S];
  logic [N-1:0] d_r   [S];

  logic         adv     [S];
  logic         load    [S];
  logic [N-1:0] src_a   [S];
  logic [N-1:0] src_b   [S];
  logic [N-1:0] src_d   [S];
  logic         src_brw [S];
  logic [N-1:0] nxt_d   [S];
  logic         nxt_brw [S];

  // Advance chain, resolved from the output end back to the input.
  always_comb begin : flow
    logic free;
    free = out_ready;
    for (int k = int'(S) - 1; k >= 0; k--) begin
      adv[k] = v[k] & free;
      free   = ~v[k] | free;
    end
    in_ready = free;
  end

  // Per-stage group resolution and load enables.
  always_comb begin : datapath
    logic [GS:0] r;
    r          = '0;
    load[0]    = in_valid & in_ready;
    src_a[0]   = a_in;
    src_b[0]   = b_in;
    src_d[0]   = '0;
    src_brw[0] = bin;
    for (int k = 1; k < int'(S); k++) begin
      load[k]    = adv[k-1];
      src_a[k]   = a_r[k-1];
      src_b[k]   = b_r[k-1];
      src_d[k]   = d_r[k-1];
      src_brw[k] = brw_r[k-1];
    end
    for (int k = 0; k < int'(S); k++) begin
      r                     = grp_sub(src_a[k][k*GS +: GS], src_b[k][k*GS +: GS], src_brw[k]);
      nxt_d[k]              = src_d[k];
      nxt_d[k][k*GS +: GS]  = r[GS-1:0];
      nxt_brw[k]            = r[GS];
    end
  end

  // Stage registers; a stage holds its token until the next one can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(S); k++) begin
        v[k]     <= 1'b0;
        brw_r[k] <= 1'b0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        d_r[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(S); k++) begin
        v[k] <= load[k] | (v[k] & ~adv[k]);
        if (load[k]) begin
          brw_r[k] <= nxt_brw[k];
          a_r[k]   <= src_a[k];
          b_r[k]   <= src_b[k];
          d_r[k]   <= nxt_d[k];
        end
      end
    end
  end

  assign out_valid = v[S-1];
  assign diff      = d_r[S-1];
  assign bout      = brw_r[S-1];
  assign ovf       = (a_r[S-1][N-1] ^ b_r[S-1][N-1]) & (d_r[S-1][N-1] ^ a_r[S-1][N-1]);

endmodule
